kbd_matrix_writer: RTL

// Writer end of the keyboard matrix interface: turns key press/release events into
// the Pi-side write cycles (pi_addr/pi_data/pi_write) the keyboard block decodes.

---
 rtl/kbd_matrix_writer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/kbd_matrix_writer.sv
`default_nettype none
// ============================================================================
// Module   : kbd_matrix_writer
// Purpose  : Converts key press/release events into full-row write cycles on
//            the keyboard matrix Pi-side bus, keeping a shadow of every row.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_matrix_writer #(
    parameter logic [15:0] BASE_ADDR     = 16'hE800,
    parameter int          NUM_ROWS      = 10,
    parameter int          SETUP_CYCLES  = 1,
    parameter int          STROBE_CYCLES = 1,
    parameter int          HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        evt_valid,
    output logic        evt_ready,
    input  logic [3:0]  evt_row,
    input  logic [2:0]  evt_col,
    input  logic        evt_pressed,
    input  logic        clear_all,
    output logic        busy,
    output logic [15:0] pi_addr,
    output logic [7:0]  pi_data,
    output logic        pi_write
);

    localparam int c_MAX_A      = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int c_MAX_CYCLES = (c_MAX_A > HOLD_CYCLES) ? c_MAX_A : HOLD_CYCLES;
    localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0] c_SETUP_LD  = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STROBE_LD = c_CNT_W'(STROBE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD   = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]         c_LAST_ROW  = 4'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_row;
    logic               r_sweep;
    logic               r_clear_pending;
    logic               r_busy;
    logic               r_write;
    logic [15:0]        r_addr;
    logic [7:0]         r_data;
    logic [7:0]         r_shadow [0:15];

    logic               w_accept;
    logic               w_row_ok;
    logic               w_changed;
    logic               w_restart;
    logic [7:0]         w_cur;
    logic [7:0]         w_mask;
    logic [7:0]         w_new;
    logic [3:0]         w_next_row;

    // Ready is withheld in the very cycle clear_all arrives so the clear wins.
    assign evt_ready  = !reset && (r_state == S_IDLE) && !r_clear_pending && !clear_all;
    assign w_accept   = evt_valid && evt_ready;
    assign w_row_ok   = (evt_row <= c_LAST_ROW);
    assign w_cur      = r_shadow[evt_row];
    assign w_mask     = 8'b1 << evt_col;
    assign w_new      = evt_pressed ? (w_cur | w_mask) : (w_cur & ~w_mask);
    assign w_changed  = (w_new != w_cur);
    assign w_restart  = r_clear_pending || clear_all;
    assign w_next_row = w_restart ? 4'd0 : (r_row + 4'd1);

    assign busy     = r_busy;
    assign pi_addr  = r_addr;
    assign pi_data  = r_data;
    assign pi_write = r_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_row           <= '0;
            r_sweep         <= 1'b0;
            r_clear_pending <= 1'b0;
            r_busy          <= 1'b0;
            r_write         <= 1'b0;
            r_addr          <= 16'h0000;
            r_data          <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= 8'h00;
            end
        end else begin
            if ((r_state != S_IDLE) && clear_all) begin
                r_clear_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (clear_all || r_clear_pending) begin
                        for (int i = 0; i < 16; i++) begin
                            r_shadow[i] <= 8'h00;
                        end
                        r_clear_pending <= 1'b0;
                        r_sweep         <= 1'b1;
                        r_row           <= 4'd0;
                        r_addr          <= BASE_ADDR;
                        r_data          <= 8'h00;
                        r_cnt           <= c_SETUP_LD;
                        r_state         <= S_SETUP;
                        r_busy          <= 1'b1;
                    end else if (w_accept && w_row_ok && w_changed) begin
                        r_shadow[evt_row] <= w_new;
                        r_sweep           <= 1'b0;
                        r_row             <= evt_row;
                        r_addr            <= BASE_ADDR + {12'b0, evt_row};
                        r_data            <= w_new;
                        r_cnt             <= c_SETUP_LD;
                        r_state           <= S_SETUP;
                        r_busy            <= 1'b1;
                    end
                end

                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_STROBE;
                        r_write <= 1'b1;
                        r_cnt   <= c_STROBE_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_STROBE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_HOLD;
                        r_write <= 1'b0;
                        r_cnt   <= c_HOLD_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_HOLD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_sweep && (w_restart || (r_row != c_LAST_ROW))) begin
                        // Next sweep row (or row 0 on restart) follows with no idle gap.
                        r_clear_pending <= 1'b0;
                        r_row           <= w_next_row;
                        r_addr          <= BASE_ADDR + {12'b0, w_next_row};
                        r_data          <= 8'h00;
                        r_cnt           <= c_SETUP_LD;
                        r_state         <= S_SETUP;
                    end else begin
                        r_state <= S_IDLE;
                        r_sweep <= 1'b0;
                        r_busy  <= 1'b0;
                        r_addr  <= 16'h0000;
                        r_data  <= 8'h00;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
